click2sync_rx_32b: RTL and testbench

Receiver stage that sits directly downstream of the 2-input click arbiter-merge. It consumes the merge's click output channel (drive pulse plus 32-bit data) and moves each token into a clocked domain through a toggle synchronizer. Each token is buffered in a small show-ahead FIFO and presented on a valid/ready stream. The click free pulse is returned upstream only after the token has been committed to the FIFO, which gives exactly one click token in flight.

---
 rtl/click2sync_rx_32b.sv | 135 +++++++++++++
 tb/tb_click2sync_rx_32b.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/click2sync_rx_32b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | click2sync_rx_32b : click-channel receiver, toggle-synchronised into clk, |
// | buffered in a show-ahead FIFO with valid/ready output.   Rev 1.0          |
// +--------------------------------------------------------------------------+
module click2sync_rx_32b #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FREE_WIDTH  = 2
) (
  input  logic                       clk,
  input  logic                       w_firstFire_1,
  input  logic                       i_drive,
  input  logic [31:0]                i_data_32,
  output logic                       o_free,
  output logic                       o_valid,
  output logic [31:0]                o_data_32,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_FCW   = (FREE_WIDTH > 1) ? $clog2(FREE_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_SPACE = 2'd1,
    S_WRITE      = 2'd2,
    S_FREE       = 2'd3
  } state_t;

  logic                   r_reqTog;
  logic [31:0]            r_hold_32;
  logic [1:0]             r_rstPipe;
  logic                   w_rstSync;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_syncLast;
  logic                   r_seen;
  logic                   w_pending;
  state_t                 r_state;
  state_t                 w_stateNext;
  logic [c_FCW-1:0]       r_freeCnt;
  logic [31:0]            r_mem [DEPTH];
  logic [c_PTR_W-1:0]     r_wrPtr;
  logic [c_PTR_W-1:0]     r_rdPtr;
  logic [c_CNT_W-1:0]     r_count;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;

  // Click side: clocked by the drive pulse itself.
  always_ff @(posedge i_drive or posedge w_firstFire_1) begin
    if (w_firstFire_1) begin
      r_hold_32 <= '0;
      r_reqTog  <= 1'b0;
    end else begin
      r_hold_32 <= i_data_32;
      r_reqTog  <= ~r_reqTog;
    end
  end

  // Asserts immediately, releases two clk edges after the system reset drops.
  always_ff @(posedge clk or posedge w_firstFire_1) begin
    if (w_firstFire_1) r_rstPipe <= 2'b11;
    else               r_rstPipe <= {r_rstPipe[0], 1'b0};
  end
  assign w_rstSync = r_rstPipe[1];

  always_ff @(posedge clk or posedge w_rstSync) begin
    if (w_rstSync) r_sync <= '0;
    else           r_sync <= {r_sync[SYNC_STAGES-2:0], r_reqTog};
  end

  assign w_syncLast = r_sync[SYNC_STAGES-1];
  assign w_pending  = (w_syncLast != r_seen);
  assign w_full     = (r_count == c_CNT_W'(DEPTH));
  assign o_valid    = (r_count != '0);
  assign w_pop      = o_valid & i_ready;
  assign w_push     = (r_state == S_WRITE);
  assign o_free     = (r_state == S_FREE);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pending) w_stateNext = w_full ? S_WAIT_SPACE : S_WRITE;
      end
      S_WAIT_SPACE: begin
        if (!w_full || w_pop) w_stateNext = S_WRITE;
      end
      S_WRITE: w_stateNext = S_FREE;
      S_FREE: begin
        if (r_freeCnt == c_FCW'(FREE_WIDTH - 1)) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge w_rstSync) begin
    if (w_rstSync) begin
      r_state   <= S_IDLE;
      r_seen    <= 1'b0;
      r_freeCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == S_IDLE && w_pending) r_seen <= w_syncLast;
      if (r_state == S_FREE && w_stateNext == S_FREE) r_freeCnt <= r_freeCnt + 1'b1;
      else                                            r_freeCnt <= '0;
    end
  end

  // r_hold_32 is stable here: upstream cannot drive again until o_free.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= r_hold_32;
  end

  always_ff @(posedge clk or posedge w_rstSync) begin
    if (w_rstSync) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign o_data_32 = o_valid ? r_mem[r_rdPtr] : 32'h0;
  assign o_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_click2sync_rx_32b.sv
`default_nettype none
// Directed bench for click2sync_rx_32b: reset, single token, back-pressure,
// wrap/ordering, simultaneous push/pop and reset mid-operation.
module tb_click2sync_rx_32b;

  logic        clk = 1'b0;
  logic        w_firstFire_1;
  logic        i_drive;
  logic [31:0] i_data_32;
  logic        o_free;
  logic        o_valid;
  logic [31:0] o_data_32;
  logic        i_ready;
  logic [2:0]  o_count;

  int n_asserts = 0;
  int n_fails   = 0;
  logic inflight = 1'b0;

  always #5 clk = ~clk;

  click2sync_rx_32b dut (
    .clk          (clk),
    .w_firstFire_1(w_firstFire_1),
    .i_drive      (i_drive),
    .i_data_32    (i_data_32),
    .o_free       (o_free),
    .o_valid      (o_valid),
    .o_data_32    (o_data_32),
    .i_ready      (i_ready),
    .o_count      (o_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A drive edge while a token is still awaiting o_free breaks the click protocol.
  always @(posedge i_drive) begin
    if (!w_firstFire_1) begin
      chk("protocol_drive_before_free", {31'd0, inflight}, 32'd0);
      inflight = 1'b1;
    end
  end
  always @(negedge o_free) inflight = 1'b0;
  always @(posedge w_firstFire_1) inflight = 1'b0;

  task automatic send(input logic [31:0] d);
    i_data_32 = d;
    #2 i_drive = 1'b1;
    #2 i_drive = 1'b0;
  endtask

  task automatic wait_free(input string tag);
    int t = 0;
    while (!o_free && t < 20) begin @(negedge clk); t++; end
    chk({tag, "_free_rise"}, {31'd0, o_free}, 32'd1);
    while (o_free && t < 40) begin @(negedge clk); t++; end
    chk({tag, "_free_fall"}, {31'd0, o_free}, 32'd0);
  endtask

  task automatic send_wait(input logic [31:0] d);
    @(negedge clk);
    send(d);
    wait_free("send");
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_data"}, o_data_32, exp);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  initial begin
    int n;
    int w;
    logic seen;
    int exp_idx;

    w_firstFire_1 = 1'b1;
    i_drive = 1'b0;
    i_ready = 1'b0;
    i_data_32 = '0;

    // Reset with random inputs
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i_data_32 = $urandom;
      i_ready = 1'($urandom_range(0, 1));
      i_drive = 1'($urandom_range(0, 1));
    end
    i_drive = 1'b0;
    i_ready = 1'b0;
    #1;
    chk("rst_free", {31'd0, o_free}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", o_data_32, 32'd0);
    chk("rst_count", {29'd0, o_count}, 32'd0);
    @(negedge clk);
    w_firstFire_1 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen = seen | o_free | o_valid;
    end
    chk("post_rst_idle", {31'd0, seen}, 32'd0);

    // Single token
    @(negedge clk);
    send(32'hA5A5_0001);
    n = 0;
    while (!o_valid && n < 8) begin @(negedge clk); n++; end
    chk("single_latency_ok", {31'd0, (n <= 4)}, 32'd1);
    chk("single_free_with_valid", {31'd0, o_free}, 32'd1);
    chk("single_data", o_data_32, 32'hA5A5_0001);
    chk("single_count", {29'd0, o_count}, 32'd1);
    w = 0;
    while (o_free && w < 10) begin @(negedge clk); w++; end
    chk("single_free_width", w, 32'd2);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("single_pop_valid", {31'd0, o_valid}, 32'd0);
    chk("single_pop_data", o_data_32, 32'd0);
    chk("single_pop_count", {29'd0, o_count}, 32'd0);

    // Fill and back-pressure
    for (int k = 0; k < 4; k++) send_wait(32'h10 + 32'(k));
    chk("fill_count", {29'd0, o_count}, 32'd4);
    @(negedge clk);
    send(32'h14);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen = seen | o_free;
    end
    chk("bp_free_withheld", {31'd0, seen}, 32'd0);
    chk("bp_count_full", {29'd0, o_count}, 32'd4);
    chk("bp_head_first", o_data_32, 32'h10);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("bp_after_pop_count", {29'd0, o_count}, 32'd3);
    chk("bp_after_pop_head", o_data_32, 32'h11);
    @(negedge clk);
    chk("bp_push_count", {29'd0, o_count}, 32'd4);
    chk("bp_push_free", {31'd0, o_free}, 32'd1);
    wait_free("bp");
    for (int k = 1; k < 5; k++) pop_check("bp_drain", 32'h10 + 32'(k));
    chk("bp_empty", {29'd0, o_count}, 32'd0);

    // Wrap-around and ordering with random consumer
    exp_idx = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) send_wait(32'h100 + 32'(k));
      end
      begin
        int t = 0;
        logic r;
        while (exp_idx < 20 && t < 3000) begin
          @(negedge clk);
          t++;
          r = 1'($urandom_range(0, 1));
          if (r && o_valid) begin
            chk("wrap_order", o_data_32, 32'h100 + 32'(exp_idx));
            exp_idx++;
          end
          i_ready = r;
        end
      end
    join
    @(negedge clk);
    i_ready = 1'b0;
    @(negedge clk);
    chk("wrap_all_delivered", exp_idx, 32'd20);
    chk("wrap_empty", {29'd0, o_count}, 32'd0);

    // Simultaneous push and pop
    send_wait(32'h200);
    send_wait(32'h201);
    @(negedge clk);
    send(32'h202);
    repeat (3) @(negedge clk);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("simul_count", {29'd0, o_count}, 32'd2);
    chk("simul_free", {31'd0, o_free}, 32'd1);
    chk("simul_head", o_data_32, 32'h201);
    wait_free("simul");
    pop_check("simul_drain", 32'h201);
    pop_check("simul_drain", 32'h202);

    // Reset mid-operation during FREE with three entries
    send_wait(32'h300);
    send_wait(32'h301);
    @(negedge clk);
    send(32'h302);
    n = 0;
    while (!o_free && n < 20) begin @(negedge clk); n++; end
    chk("midrst_pre_count", {29'd0, o_count}, 32'd3);
    #1 w_firstFire_1 = 1'b1;
    #1;
    chk("midrst_free", {31'd0, o_free}, 32'd0);
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_data", o_data_32, 32'd0);
    chk("midrst_count", {29'd0, o_count}, 32'd0);
    repeat (3) @(negedge clk);
    w_firstFire_1 = 1'b0;
    repeat (4) @(negedge clk);
    send(32'hDEAD_BEEF);
    n = 0;
    while (!o_valid && n < 8) begin @(negedge clk); n++; end
    chk("midrst_new_count", {29'd0, o_count}, 32'd1);
    chk("midrst_new_data", o_data_32, 32'hDEAD_BEEF);
    wait_free("midrst");
    pop_check("midrst_sole", 32'hDEAD_BEEF);
    chk("midrst_final_empty", {31'd0, o_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
